// File: rtl/current_loop_pi_seq.sv
// FOC current-loop sequencer: one control period emits Vd/Vq, waits for Id/Iq, then runs d/q PI on one shared multiplier.
// Measurement watchdog is built only when CL_MEAS_TIMEOUT_EN is defined; otherwise oFault is tied to 0.
module current_loop_pi_seq #(
  parameter int IW      = 12,
  parameter int VW      = 16,
  parameter int KW      = 10,
  parameter int SHIFT   = 10,
  parameter int VLIM    = 4000,
  parameter int TIMEOUT = 4096
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iCL_en,
  input  logic                 iMode,
  input  logic signed [IW-1:0] iId_set,
  input  logic signed [IW-1:0] iIq_set,
  input  logic signed [VW-1:0] iVd_ol,
  input  logic signed [VW-1:0] iVq_ol,
  input  logic        [KW-1:0] iKp,
  input  logic        [KW-1:0] iKi,
  input  logic                 iMeas_done,
  input  logic signed [IW-1:0] iId_meas,
  input  logic signed [IW-1:0] iIq_meas,
  output logic signed [VW-1:0] oVd,
  output logic signed [VW-1:0] oVq,
  output logic                 oVdq_valid,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oSat_d,
  output logic                 oSat_q,
  output logic                 oFault,
  output logic                 oOverrun
);

  localparam int EW  = IW + 1;
  localparam int GW  = KW + 1;
  localparam int PW  = IW + KW + 2;
  localparam int ACC = VW + SHIFT + 1;
  localparam int AW1 = ACC + 1;
  localparam int SW  = ACC + 1;

  localparam logic signed [ACC-1:0] ILIM   = ACC'(longint'(VLIM) <<< SHIFT);
  localparam logic signed [AW1-1:0] ILIM_X = AW1'(longint'(VLIM) <<< SHIFT);
  localparam logic signed [VW-1:0]  VMAX   = VW'(VLIM);
  localparam logic signed [SW-1:0]  VMAX_S = SW'(VLIM);

  typedef enum logic [3:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_ERR, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_UPD, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic                  mode_q, mode_d;
  logic signed [EW-1:0]  ed_q, ed_d, eq_q, eq_d;
  logic        [KW-1:0]  kp_q, kp_d, ki_q, ki_d;
  logic signed [PW-1:0]  pd_q, pd_d, pq_q, pq_d;
  logic signed [ACC-1:0] intd_q, intd_d, intq_q, intq_d;
  logic signed [VW-1:0]  vd_q, vd_d, vq_q, vq_d;
  logic                  satd_q, satd_d, satq_q, satq_d;
  logic                  ovr_q, ovr_d;
  logic                  fault_q, fault_d;

  // Shared multiplier: operand pair is chosen by which MUL state is active.
  logic signed [EW-1:0] mul_e;
  logic        [KW-1:0] mul_k;
  logic signed [GW-1:0] mul_g;
  logic signed [PW-1:0] mul_p;

  always_comb begin
    mul_e = ed_q;
    mul_k = kp_q;
    unique case (state_q)
      S_MUL1:  mul_k = ki_q;
      S_MUL2:  mul_e = eq_q;
      S_MUL3:  begin mul_e = eq_q; mul_k = ki_q; end
      default: ;
    endcase
  end

  assign mul_g = {1'b0, mul_k};
  assign mul_p = PW'(mul_e) * PW'(mul_g);

  function automatic logic signed [ACC-1:0] integ_next(input logic signed [ACC-1:0] acc,
                                                       input logic signed [PW-1:0]  p);
    logic signed [AW1-1:0] s;
    s = AW1'(acc) + AW1'(p);
    if (s > ILIM_X)
      return ILIM;
    else if (s < -ILIM_X)
      return -ILIM;
    else
      return s[ACC-1:0];
  endfunction

  // Returns {saturated, voltage}.
  function automatic logic [VW:0] v_out(input logic signed [PW-1:0]  p,
                                       input logic signed [ACC-1:0] acc);
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] sh;
    s  = SW'(p) + SW'(acc);
    sh = s >>> SHIFT;
    if (sh > VMAX_S)
      return {1'b1, VMAX};
    else if (sh < -VMAX_S)
      return {1'b1, -VMAX};
    else
      return {1'b0, sh[VW-1:0]};
  endfunction

  logic [VW:0] vd_res, vq_res;
  assign vd_res = v_out(pd_q, intd_q);
  assign vq_res = v_out(pq_q, intq_q);

`ifdef CL_MEAS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q;
  logic          to_hit;

  always_ff @(posedge iClk) begin
    if (iRst || state_q != S_WAIT)
      to_cnt_q <= '0;
    else
      to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign to_hit = (to_cnt_q == TW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ed_d    = ed_q;
    eq_d    = eq_q;
    kp_d    = kp_q;
    ki_d    = ki_q;
    pd_d    = pd_q;
    pq_d    = pq_q;
    intd_d  = intd_q;
    intq_d  = intq_q;
    vd_d    = vd_q;
    vq_d    = vq_q;
    satd_d  = satd_q;
    satq_d  = satq_q;
    fault_d = fault_q;
    ovr_d   = ovr_q | (iCL_en && (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (iCL_en) begin
          mode_d  = iMode;
          state_d = S_LAUNCH;
          if (!iMode) begin
            vd_d = iVd_ol;
            vq_d = iVq_ol;
          end
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (iMeas_done) begin
          ed_d = EW'(iId_set) - EW'(iId_meas);
          eq_d = EW'(iIq_set) - EW'(iIq_meas);
          if (mode_q) begin
            state_d = S_ERR;
          end else begin
            // Open loop must not leave stale integral for a later closed-loop period.
            intd_d  = '0;
            intq_d  = '0;
            state_d = S_DONE;
          end
        end
`ifdef CL_MEAS_TIMEOUT_EN
        else if (to_hit) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_ERR: begin
        kp_d    = iKp;
        ki_d    = iKi;
        state_d = S_MUL0;
      end
      S_MUL0: begin
        pd_d    = mul_p;
        state_d = S_MUL1;
      end
      S_MUL1: begin
        intd_d  = integ_next(intd_q, mul_p);
        state_d = S_MUL2;
      end
      S_MUL2: begin
        pq_d    = mul_p;
        state_d = S_MUL3;
      end
      S_MUL3: begin
        intq_d  = integ_next(intq_q, mul_p);
        state_d = S_UPD;
      end
      S_UPD: begin
        satd_d  = vd_res[VW];
        vd_d    = vd_res[VW-1:0];
        satq_d  = vq_res[VW];
        vq_d    = vq_res[VW-1:0];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      ed_q    <= '0;
      eq_q    <= '0;
      kp_q    <= '0;
      ki_q    <= '0;
      pd_q    <= '0;
      pq_q    <= '0;
      intd_q  <= '0;
      intq_q  <= '0;
      vd_q    <= '0;
      vq_q    <= '0;
      satd_q  <= 1'b0;
      satq_q  <= 1'b0;
      ovr_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ed_q    <= ed_d;
      eq_q    <= eq_d;
      kp_q    <= kp_d;
      ki_q    <= ki_d;
      pd_q    <= pd_d;
      pq_q    <= pq_d;
      intd_q  <= intd_d;
      intq_q  <= intq_d;
      vd_q    <= vd_d;
      vq_q    <= vq_d;
      satd_q  <= satd_d;
      satq_q  <= satq_d;
      ovr_q   <= ovr_d;
      fault_q <= fault_d;
    end
  end

  assign oVd        = vd_q;
  assign oVq        = vq_q;
  assign oVdq_valid = (state_q == S_LAUNCH);
  assign oBusy      = (state_q != S_IDLE);
  assign oDone      = (state_q == S_DONE);
  assign oSat_d     = satd_q;
  assign oSat_q     = satq_q;
  assign oOverrun   = ovr_q;

`ifdef CL_MEAS_TIMEOUT_EN
  assign oFault = fault_q;
`else
  // Without the watchdog nothing can set the fault; the compare keeps TIMEOUT referenced.
  assign oFault = (TIMEOUT < 0) | fault_q;
`endif

endmodule

// File: tb/tb_current_loop_pi_seq.sv
// Scoreboard bench for current_loop_pi_seq: expected voltages are pushed at measurement time and popped on oDone.
module tb_current_loop_pi_seq;

  localparam int IW = 12, VW = 16, KW = 10, SHIFT = 10, VLIM = 4000, TIMEOUT = 16;
  localparam longint ILIM = longint'(VLIM) * (longint'(1) << SHIFT);

  logic clk = 1'b0;
  logic rst = 1'b1, cl_en = 1'b0, mode = 1'b0, meas_done = 1'b0;
  logic signed [IW-1:0] id_set = '0, iq_set = '0, id_meas = '0, iq_meas = '0;
  logic signed [VW-1:0] vd_ol = '0, vq_ol = '0;
  logic        [KW-1:0] kp = '0, ki = '0;
  logic signed [VW-1:0] vd, vq;
  logic vdq_valid, busy, done, sat_d, sat_q, fault, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { longint vd; longint vq; longint sd; longint sq; } exp_t;
  exp_t sb[$];

  longint m_intd = 0, m_intq = 0, m_vd = 0, m_vq = 0, m_sd = 0, m_sq = 0;

  current_loop_pi_seq #(
    .IW(IW), .VW(VW), .KW(KW), .SHIFT(SHIFT), .VLIM(VLIM), .TIMEOUT(TIMEOUT)
  ) dut (
    .iClk(clk), .iRst(rst), .iCL_en(cl_en), .iMode(mode),
    .iId_set(id_set), .iIq_set(iq_set), .iVd_ol(vd_ol), .iVq_ol(vq_ol),
    .iKp(kp), .iKi(ki), .iMeas_done(meas_done),
    .iId_meas(id_meas), .iIq_meas(iq_meas),
    .oVd(vd), .oVq(vq), .oVdq_valid(vdq_valid), .oBusy(busy), .oDone(done),
    .oSat_d(sat_d), .oSat_q(sat_q), .oFault(fault), .oOverrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference PI for one axis, straight from the control law.
  task automatic axis_model(input longint e, input longint kpv, input longint kiv,
                            inout longint acc, output longint v, output longint s);
    longint t;
    acc = acc + kiv * e;
    if (acc > ILIM) acc = ILIM;
    if (acc < -ILIM) acc = -ILIM;
    t = (kpv * e + acc) >>> SHIFT;
    s = 0;
    if (t > VLIM) begin t = VLIM; s = 1; end
    if (t < -VLIM) begin t = -VLIM; s = 1; end
    v = t;
  endtask

  task automatic run_period(input logic md, input longint ids, input longint iqs,
                            input longint idm, input longint iqm,
                            input longint vdo, input longint vqo,
                            input longint kpv, input longint kiv,
                            input int dly, input bit extra_en);
    exp_t e, got;
    int n;
    mode = md;
    id_set = IW'(ids); iq_set = IW'(iqs); id_meas = IW'(idm); iq_meas = IW'(iqm);
    vd_ol = VW'(vdo); vq_ol = VW'(vqo); kp = KW'(kpv); ki = KW'(kiv);
    cl_en = 1'b1;
    @(negedge clk);
    cl_en = 1'b0;
    check_val("vdq_valid_c1", vdq_valid, 1);
    if (!md) begin
      check_val("ol_vd_c1", vd, vdo);
      check_val("ol_vq_c1", vq, vqo);
    end
    @(negedge clk);
    check_val("vdq_valid_c2", vdq_valid, 0);
    if (extra_en) begin
      cl_en = 1'b1;
      @(negedge clk);
      cl_en = 1'b0;
      check_val("overrun_set", overrun, 1);
      check_val("busy_after_overrun", busy, 1);
    end
    repeat (dly) @(negedge clk);

    if (md) begin
      axis_model(ids - idm, kpv, kiv, m_intd, m_vd, m_sd);
      axis_model(iqs - iqm, kpv, kiv, m_intq, m_vq, m_sq);
    end else begin
      m_vd = vdo; m_vq = vqo; m_intd = 0; m_intq = 0;
    end
    e.vd = m_vd; e.vq = m_vq; e.sd = m_sd; e.sq = m_sq;
    sb.push_back(e);

    meas_done = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      meas_done = 1'b0;
      n++;
    end while (!done && n < 40);
    check_val(md ? "cl_done_latency" : "ol_done_latency", n, md ? 7 : 1);
    got.vd = vd; got.vq = vq; got.sd = sat_d; got.sq = sat_q;
    e = sb.pop_front();
    check_val("vd", got.vd, e.vd);
    check_val("vq", got.vq, e.vq);
    check_val("sat_d", got.sd, e.sd);
    check_val("sat_q", got.sq, e.sq);
    @(negedge clk);
    check_val("done_one_cycle", done, 0);
    check_val("busy_after_done", busy, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_vd", vd, 0);
    check_val("rst_vq", vq, 0);
    check_val("rst_valid", vdq_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_sat_d", sat_d, 0);
    check_val("rst_sat_q", sat_q, 0);
    check_val("rst_fault", fault, 0);
    check_val("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    // Stray measurement in IDLE must not start anything.
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    check_val("idle_meas_busy", busy, 0);
    check_val("idle_meas_done", done, 0);

    run_period(1'b0, 0, 0, 0, 0, 0, -1000, 0, 0, 20, 1'b0);
    run_period(1'b1, 0, 100, 0, 0, 0, 0, 1023, 0, 3, 1'b0);
    run_period(1'b1, 0, 100, 0, 0, 0, 0, 1023, 0, 3, 1'b0);
    run_period(1'b1, -30, 100, 10, 0, 0, 0, 0, 512, 3, 1'b0);
    run_period(1'b1, -30, 100, 10, 0, 0, 0, 0, 512, 3, 1'b1);
    run_period(1'b1, -30, 100, 10, 0, 0, 0, 0, 512, 3, 1'b0);
    run_period(1'b0, 0, 0, 0, 0, 123, -456, 0, 0, 2, 1'b0);
    run_period(1'b1, 500, 2047, 0, -2048, 0, 0, 1023, 0, 3, 1'b0);
    run_period(1'b1, -500, -2048, 0, 2047, 0, 0, 1023, 0, 3, 1'b0);

    // Reset while the FSM sits in MUL1.
    mode = 1'b1; id_set = 12'sd40; iq_set = 12'sd60; id_meas = '0; iq_meas = '0;
    kp = 10'd300; ki = 10'd200;
    cl_en = 1'b1;
    @(negedge clk);
    cl_en = 1'b0;
    repeat (3) @(negedge clk);
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    repeat (2) @(negedge clk);
    check_val("busy_in_mul1", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mrst_vd", vd, 0);
    check_val("mrst_vq", vq, 0);
    check_val("mrst_busy", busy, 0);
    check_val("mrst_sat_q", sat_q, 0);
    check_val("mrst_overrun", overrun, 0);
    check_val("mrst_done", done, 0);
    m_intd = 0; m_intq = 0; m_vd = 0; m_vq = 0; m_sd = 0; m_sq = 0;
    run_period(1'b1, 40, -60, 0, 0, 0, 0, 256, 128, 2, 1'b0);
    run_period(1'b1, 40, -60, 0, 0, 0, 0, 256, 128, 2, 1'b0);

`ifdef CL_MEAS_TIMEOUT_EN
    mode = 1'b1;
    cl_en = 1'b1;
    @(negedge clk);
    cl_en = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("wd_done_cycle", n, 18);
    check_val("wd_fault", fault, 1);
    check_val("wd_vd_kept", vd, m_vd);
    check_val("wd_vq_kept", vq, m_vq);
    @(negedge clk);
    check_val("wd_busy_after", busy, 0);
    run_period(1'b1, 40, -60, 0, 0, 0, 0, 256, 128, 2, 1'b0);
    check_val("wd_fault_sticky", fault, 1);
`else
    n = 0;
    check_val("no_wd_fault", fault, n);
`endif

    check_val("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got 1 expected 0");
    $fatal(1);
  end

endmodule

// File: doc/current_loop_pi_seq.md
# current_loop_pi_seq

Parametrised closed-loop current controller sequencer for the FOC datapath. It sits between the rotor-angle/ADC front end and the inverse-Park/SVPWM chain, and replaces the fixed Vd/Vq constants with runtime-selectable open-loop voltages or dual d/q PI regulation. Each control period follows the same order: emit voltages, wait for the measured Id/Iq, then run both PI updates on one shared multiplier. An optional watchdog faults on a missing measurement.

## Interface
- IW, 12: signed current width (setpoints, measurements)
- VW, 16: signed voltage width (oVd/oVq, open-loop inputs)
- KW, 10: unsigned gain width
- SHIFT, 10: fixed-point right shift applied to the PI sum
- VLIM, 4000: symmetric output/integrator clamp magnitude, 0 < VLIM < 2^(VW-1)
- TIMEOUT, 4096: measurement watchdog cycles (used only with CL_MEAS_TIMEOUT_EN)

- iClk  in  1  clock; one clock only
- iRst  in  1  reset; synchronous, active-high
- iCL_en  in  1  control-period start pulse
- iMode  in  1  0 = open loop, 1 = closed loop; sampled with iCL_en
- iId_set, iIq_set  in  IW  signed current setpoints
- iVd_ol, iVq_ol  in  VW  signed open-loop voltages
- iKp, iKi  in  KW  unsigned gains, shared by d and q
- iMeas_done  in  1  measurement-valid pulse from the ADC treatment block
- iId_meas, iIq_meas  in  IW  signed measured currents; valid with iMeas_done
- oVd, oVq  out  VW  signed voltage commands to inverse Park
- oVdq_valid  out  1  one-cycle launch pulse for inverse Park
- oBusy  out  1  high whenever the FSM is not in IDLE
- oDone  out  1  one-cycle pulse at the end of a period
- oSat_d, oSat_q  out  1  the last update clamped that axis
- oFault  out  1  sticky; measurement timeout
- oOverrun  out  1  sticky; iCL_en arrived while busy

## Operation
- Reset values: every output is 0. Both integrators are 0. The FSM is in IDLE.
- FSM states: IDLE, LAUNCH, WAIT, ERR, MUL0, MUL1, MUL2, MUL3, UPD, DONE.
- IDLE: when iCL_en=1, latch iMode and go to LAUNCH.
  - Open loop: also latch iVd_ol/iVq_ol into oVd/oVq.
  - Closed loop: oVd/oVq keep the result of the previous period.
- LAUNCH: oVdq_valid=1 for this cycle only, then go to WAIT.
- WAIT: when iMeas_done=1, latch the errors and go to ERR.
  - Errors: ed = iId_set − iId_meas and eq = iIq_set − iIq_meas, each signed IW+1.
  - Open loop: go straight to DONE and clear both integrators.
- ERR → MUL0..MUL3: one shared signed multiplier computes in turn Kp·ed, Ki·ed, Kp·eq, Ki·eq.
  - Gains are zero-extended to KW+1 bits; products are IW+KW+2 bits.
- Integrator: I += Ki·e, sign-extended to an ACC = VW+SHIFT+1 bit accumulator, then clamped to ±(VLIM<<SHIFT).
- Output: v = (Kp·e + I) >>> SHIFT, arithmetic shift, then clamped to ±VLIM. oSat_x=1 when the clamp was applied.
- UPD: oVd/oVq/oSat_d/oSat_q are registered. Then go to DONE.
- DONE: oDone=1 for one cycle, then go to IDLE.
- iCL_en outside IDLE is ignored and sets oOverrun, including when it coincides with DONE.
- iMeas_done outside WAIT is ignored.
- iRst in any state returns all outputs, integrators and the FSM to reset values at that edge.

## Timing
- iCL_en sampled at edge 0 → oVdq_valid high in cycle 1. oVd/oVq are already stable in cycle 1.
- Closed loop: iMeas_done sampled at edge t → new oVd/oVq and oDone both visible in cycle t+7.
- Open loop: iMeas_done sampled at edge t → oDone high in cycle t+1.
- Earliest next accepted iCL_en: the cycle after oDone.

## Configuration
- CL_MEAS_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - After TIMEOUT cycles without iMeas_done: set oFault, pulse oDone, return to IDLE.
  - On timeout, oVd/oVq and the integrators are unchanged.
- CL_MEAS_TIMEOUT_EN undefined: WAIT waits indefinitely, oFault is constant 0, and no counter is synthesised.

## Test plan
- Reset: assert iRst mid-MUL1 → next cycle all outputs 0, oBusy=0; a following iCL_en gives oVdq_valid one cycle later.
- Open loop: iMode=0, iVd_ol=0, iVq_ol=−1000, pulse iCL_en, iMeas_done 20 cycles later → oVd=0, oVq=−1000, oDone one cycle after iMeas_done.
- Proportional: iMode=1, iKp=1023, iKi=0, SHIFT=10, iIq_set=100, meas 0 → oVq=99 at t+7. Second period → oVq unchanged.
- Integral: iKp=0, iKi=512, eq=100 for three periods → oVq=50, 100, 150.
- Saturation: iKp=1023, iIq_set=2047, iIq_meas=−2048 → oVq=+4000, oSat_q=1. Invert the error → oVq=−4000.
- Watchdog/overrun (macro on, TIMEOUT=16): no iMeas_done → oFault=1 and oDone at cycle 18. An extra iCL_en during WAIT → oOverrun=1.
